// File: rtl/trigger_capture_pkg.sv
// Shared definitions for the capture controller: state encoding, buffer depth
// derivation and the pre-trigger legality rule.
package trigger_capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREFILL,
        ARMED,
        POST,
        DONE
    } captureState_t;

    function automatic int depthOf(input int addressBits);
        return 1 << addressBits;
    endfunction

    // The window must hold the history, the trigger sample and at least one later sample.
    function automatic bit preTriggerLegal(input int preTrigger, input int addressBits);
        return (preTrigger >= 1) && (preTrigger <= depthOf(addressBits) - 2);
    endfunction

endpackage

// File: rtl/trigger_capture_sample.sv
// Circular sample store: one synchronous write port and one registered read port,
// kept in the plain form that maps onto block RAM.
module sample_ram
    import trigger_capture_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int ADDRESS_BITS = 9
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    writeEnable,
    input  logic [ADDRESS_BITS-1:0] writeAddress,
    input  logic [DATA_BITS-1:0]    writeData,
    input  logic [ADDRESS_BITS-1:0] readAddress,
    output logic [DATA_BITS-1:0]    readData
);

    localparam int DEPTH = depthOf(ADDRESS_BITS);

    logic [DATA_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (writeEnable) begin
            mem[writeAddress] <= writeData;
        end
    end

    // Only the output register is cleared; the array contents survive reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            readData <= '0;
        end else begin
            readData <= mem[readAddress];
        end
    end

endmodule

// File: rtl/trigger_capture.sv
// Capture controller: streams samples into a circular buffer, arms the trigger and
// freezes a window with programmable pre-trigger history for trigger-relative readout.
module trigger_capture
    import trigger_capture_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int ADDRESS_BITS = 9,
    parameter int PRE_TRIGGER  = 128
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [DATA_BITS-1:0]    dataIn,
    input  logic                    isTriggered,
    input  logic                    arm,
    input  logic [ADDRESS_BITS-1:0] readIndex,
    output logic                    triggerDisable,
    output logic                    captureDone,
    output logic [DATA_BITS-1:0]    readData,
    output logic [ADDRESS_BITS-1:0] startAddress
);

    localparam int DEPTH = depthOf(ADDRESS_BITS);
    localparam logic [ADDRESS_BITS-1:0] PREFILL_LAST = ADDRESS_BITS'(PRE_TRIGGER - 1);
    localparam logic [ADDRESS_BITS-1:0] POST_LOAD    = ADDRESS_BITS'(DEPTH - PRE_TRIGGER - 2);
    localparam logic [ADDRESS_BITS-1:0] START_OFFSET = ADDRESS_BITS'(PRE_TRIGGER + 1);

    if (!preTriggerLegal(PRE_TRIGGER, ADDRESS_BITS)) begin : gIllegalPreTrigger
        $error("trigger_capture: PRE_TRIGGER must lie in 1..DEPTH-2");
    end

    captureState_t              state;
    logic [ADDRESS_BITS-1:0]    wp;
    logic [ADDRESS_BITS-1:0]    prefillCount;
    logic [ADDRESS_BITS-1:0]    postCount;
    logic                       armedSettled;
    logic                       writeEnable;
    logic [ADDRESS_BITS-1:0]    readAddress;

    assign writeEnable = !reset && (state == PREFILL || state == ARMED || state == POST);
    assign readAddress = startAddress + readIndex;

    // The trigger-detect cycle itself writes one post-trigger sample, so POST holds
    // DEPTH-PRE_TRIGGER-2 further writes; the first ARMED cycle never honours a trigger.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            wp             <= '0;
            prefillCount   <= '0;
            postCount      <= '0;
            armedSettled   <= 1'b0;
            startAddress   <= '0;
            triggerDisable <= 1'b1;
            captureDone    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (arm) begin
                        state        <= PREFILL;
                        prefillCount <= '0;
                        captureDone  <= 1'b0;
                    end
                end
                PREFILL: begin
                    wp <= wp + 1'b1;
                    if (prefillCount == PREFILL_LAST) begin
                        state          <= ARMED;
                        armedSettled   <= 1'b0;
                        triggerDisable <= 1'b0;
                    end else begin
                        prefillCount <= prefillCount + 1'b1;
                    end
                end
                ARMED: begin
                    wp           <= wp + 1'b1;
                    armedSettled <= 1'b1;
                    if (armedSettled && isTriggered) begin
                        startAddress   <= wp - START_OFFSET;
                        triggerDisable <= 1'b1;
                        postCount      <= POST_LOAD;
                        if (POST_LOAD == '0) begin
                            state       <= DONE;
                            captureDone <= 1'b1;
                        end else begin
                            state <= POST;
                        end
                    end
                end
                POST: begin
                    wp <= wp + 1'b1;
                    if (postCount == ADDRESS_BITS'(1)) begin
                        state       <= DONE;
                        captureDone <= 1'b1;
                    end
                    postCount <= postCount - 1'b1;
                end
                default: begin
                    state          <= IDLE;
                    triggerDisable <= 1'b1;
                end
            endcase
        end
    end

    sample_ram #(
        .DATA_BITS   (DATA_BITS),
        .ADDRESS_BITS(ADDRESS_BITS)
    ) ram (
        .clock       (clock),
        .reset       (reset),
        .writeEnable (writeEnable),
        .writeAddress(wp),
        .writeData   (dataIn),
        .readAddress (readAddress),
        .readData    (readData)
    );

endmodule

// File: tb/tb_trigger_capture.sv
// Self-checking bench for trigger_capture: windows are predicted from the recorded
// input stream and the trigger cycle, independent of the controller's internals.
module tb_trigger_capture;

    localparam int D     = 8;
    localparam int A     = 4;
    localparam int PRE   = 4;
    localparam int DEPTH = 1 << A;
    localparam int POST_EDGES = DEPTH - PRE - 2;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [D-1:0] dataIn = '0;
    logic         isTriggered = 1'b0;
    logic         arm = 1'b1;
    logic [A-1:0] readIndex = '0;
    logic         triggerDisable;
    logic         captureDone;
    logic [D-1:0] readData;
    logic [A-1:0] startAddress;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int rampBase = 0;
    bit rampMode = 1'b0;
    int expWp = 0;
    logic [D-1:0] hist [int];
    logic [D-1:0] rb [DEPTH];

    trigger_capture #(.DATA_BITS(D), .ADDRESS_BITS(A), .PRE_TRIGGER(PRE)) dut (
        .clock(clock), .reset(reset), .dataIn(dataIn), .isTriggered(isTriggered),
        .arm(arm), .readIndex(readIndex), .triggerDisable(triggerDisable),
        .captureDone(captureDone), .readData(readData), .startAddress(startAddress)
    );

    always #5 clock = ~clock;

    // One clock: inputs for the new cycle are driven and outputs settle 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        if (rampMode) dataIn = D'(cyc - rampBase);
        else          dataIn = D'($urandom);
        hist[cyc] = dataIn;
    endtask

    // Window index i holds the sample seen PRE+1-i cycles before the trigger-detect cycle.
    function automatic logic [D-1:0] expWin(input int trigCyc, input int i);
        return hist[trigCyc - 1 - PRE + i];
    endfunction

    function automatic logic [A-1:0] expStartFor(input int k);
        return A'(expWp + k - 1);
    endfunction

    // Arm, then pulse the trigger in the k-th ARMED cycle (k counted from 0).
    task automatic runToTrigger(input int k, output int trigCyc);
        arm = 1'b1;
        step();
        arm = 1'b0;
        repeat (PRE + k) step();
        isTriggered = 1'b1;
        trigCyc = cyc;
        step();
        isTriggered = 1'b0;
    endtask

    task automatic waitDone(output int n);
        n = 0;
        while (n < 40 && !captureDone) begin
            step();
            n++;
        end
    endtask

    task automatic readWindow();
        for (int i = 0; i < DEPTH; i++) begin
            readIndex = A'(i);
            step();
            rb[i] = readData;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        arm = 1'b1;
        for (int r = 0; r < 3; r++) begin
            step();
            compared++; if (triggerDisable !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_trigDis: got %b expected 1", triggerDisable); end
            compared++; if (captureDone !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", captureDone); end
            compared++; if (readData !== '0) begin mismatched++; $display("[TB] FAIL reset_readData: got %0d expected 0", readData); end
            compared++; if (startAddress !== '0) begin mismatched++; $display("[TB] FAIL reset_start: got %0d expected 0", startAddress); end
        end
        reset = 1'b0;
        arm = 1'b0;
        step();
        compared++; if (triggerDisable !== 1'b1 || captureDone !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_idle: got dis=%b done=%b expected dis=1 done=0", triggerDisable, captureDone); end
        expWp = 0;
    endtask

    task automatic test_basic_capture();
        int tc;
        rampMode = 1'b1;
        rampBase = cyc;
        step();
        runToTrigger(25, tc);
        compared++; if (triggerDisable !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_postDis: got %b expected 1", triggerDisable); end
        for (int n = 1; n <= POST_EDGES; n++) begin
            step();
            compared++; if (captureDone !== (n == POST_EDGES)) begin mismatched++; $display("[TB] FAIL basic_doneTiming n=%0d: got %b expected %b", n, captureDone, n == POST_EDGES); end
        end
        compared++; if (startAddress !== expStartFor(25)) begin mismatched++; $display("[TB] FAIL basic_start: got %0d expected %0d", startAddress, expStartFor(25)); end
        expWp = int'(expStartFor(25));
        readWindow();
        for (int i = 0; i < DEPTH; i++) begin
            compared++; if (rb[i] !== D'(26 + i)) begin mismatched++; $display("[TB] FAIL basic_read[%0d]: got %0d expected %0d", i, rb[i], 26 + i); end
        end
        rampMode = 1'b0;
    endtask

    task automatic test_early_trigger();
        int tc, n;
        arm = 1'b1;
        step();
        arm = 1'b0;
        isTriggered = 1'b1;
        for (int p = 0; p < PRE; p++) begin
            compared++; if (triggerDisable !== 1'b1) begin mismatched++; $display("[TB] FAIL early_prefillDis[%0d]: got %b expected 1", p, triggerDisable); end
            step();
        end
        compared++; if (triggerDisable !== 1'b0) begin mismatched++; $display("[TB] FAIL early_armedDis: got %b expected 0", triggerDisable); end
        step();
        isTriggered = 1'b0;
        compared++; if (triggerDisable !== 1'b0 || captureDone !== 1'b0) begin mismatched++; $display("[TB] FAIL early_stillArmed: got dis=%b done=%b expected dis=0 done=0", triggerDisable, captureDone); end
        step();
        step();
        isTriggered = 1'b1;
        tc = cyc;
        step();
        isTriggered = 1'b0;
        waitDone(n);
        compared++; if (n !== POST_EDGES) begin mismatched++; $display("[TB] FAIL early_doneLatency: got %0d expected %0d", n, POST_EDGES); end
        compared++; if (startAddress !== expStartFor(3)) begin mismatched++; $display("[TB] FAIL early_start: got %0d expected %0d", startAddress, expStartFor(3)); end
        expWp = int'(expStartFor(3));
        readWindow();
        for (int i = 0; i < DEPTH; i++) begin
            compared++; if (rb[i] !== expWin(tc, i)) begin mismatched++; $display("[TB] FAIL early_read[%0d]: got %0d expected %0d", i, rb[i], expWin(tc, i)); end
        end
    endtask

    task automatic test_wrap_around();
        int tc, n, k;
        k = (13 - expWp + 1) % DEPTH;
        if (k < 1) k += DEPTH;
        rampMode = 1'b1;
        rampBase = cyc;
        runToTrigger(k, tc);
        waitDone(n);
        compared++; if (n !== POST_EDGES) begin mismatched++; $display("[TB] FAIL wrap_doneLatency: got %0d expected %0d", n, POST_EDGES); end
        compared++; if (startAddress !== 4'd13) begin mismatched++; $display("[TB] FAIL wrap_start: got %0d expected 13", startAddress); end
        expWp = 13;
        readWindow();
        for (int i = 0; i < DEPTH; i++) begin
            compared++; if (rb[i] !== expWin(tc, i)) begin mismatched++; $display("[TB] FAIL wrap_read[%0d]: got %0d expected %0d", i, rb[i], expWin(tc, i)); end
        end
        rampMode = 1'b0;
    endtask

    task automatic test_rearm();
        int tc, n, k;
        k = int'($urandom_range(1, 12));
        runToTrigger(k, tc);
        n = 0;
        while (n < 40 && !captureDone) begin
            arm = (n == 2);
            step();
            n++;
        end
        arm = 1'b0;
        compared++; if (n !== POST_EDGES) begin mismatched++; $display("[TB] FAIL rearm_postArmIgnored: got %0d expected %0d", n, POST_EDGES); end
        compared++; if (startAddress !== expStartFor(k)) begin mismatched++; $display("[TB] FAIL rearm_start: got %0d expected %0d", startAddress, expStartFor(k)); end
        expWp = int'(expStartFor(k));
        readWindow();
        for (int i = 0; i < DEPTH; i++) begin
            compared++; if (rb[i] !== expWin(tc, i)) begin mismatched++; $display("[TB] FAIL rearm_read[%0d]: got %0d expected %0d", i, rb[i], expWin(tc, i)); end
        end
        arm = 1'b1;
        isTriggered = 1'b1;
        step();
        arm = 1'b0;
        isTriggered = 1'b0;
        compared++; if (captureDone !== 1'b0) begin mismatched++; $display("[TB] FAIL rearm_doneDrop: got %b expected 0", captureDone); end
        for (int p = 0; p < PRE; p++) begin
            compared++; if (triggerDisable !== 1'b1) begin mismatched++; $display("[TB] FAIL rearm_prefillDis[%0d]: got %b expected 1", p, triggerDisable); end
            step();
        end
        compared++; if (triggerDisable !== 1'b0) begin mismatched++; $display("[TB] FAIL rearm_armedDis: got %b expected 0", triggerDisable); end
    endtask

    task automatic test_reset_mid_post();
        int tc, n, k;
        reset = 1'b1;
        step();
        reset = 1'b0;
        expWp = 0;
        runToTrigger(2, tc);
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        compared++; if (captureDone !== 1'b0 || triggerDisable !== 1'b1) begin mismatched++; $display("[TB] FAIL midpost_idle: got done=%b dis=%b expected done=0 dis=1", captureDone, triggerDisable); end
        compared++; if (startAddress !== '0) begin mismatched++; $display("[TB] FAIL midpost_start: got %0d expected 0", startAddress); end
        isTriggered = 1'b1;
        step();
        isTriggered = 1'b0;
        repeat (20) step();
        compared++; if (captureDone !== 1'b0 || triggerDisable !== 1'b1) begin mismatched++; $display("[TB] FAIL midpost_trigIgnored: got done=%b dis=%b expected done=0 dis=1", captureDone, triggerDisable); end
        k = int'($urandom_range(1, 20));
        runToTrigger(k, tc);
        waitDone(n);
        compared++; if (n !== POST_EDGES) begin mismatched++; $display("[TB] FAIL midpost_doneLatency: got %0d expected %0d", n, POST_EDGES); end
        compared++; if (startAddress !== expStartFor(k)) begin mismatched++; $display("[TB] FAIL midpost_wpFrozen: got %0d expected %0d", startAddress, expStartFor(k)); end
        readWindow();
        for (int i = 0; i < DEPTH; i++) begin
            compared++; if (rb[i] !== expWin(tc, i)) begin mismatched++; $display("[TB] FAIL midpost_read[%0d]: got %0d expected %0d", i, rb[i], expWin(tc, i)); end
        end
    endtask

    initial begin
        hist[0] = '0;
        test_reset();
        test_basic_capture();
        test_early_trigger();
        test_wrap_around();
        test_rearm();
        test_reset_mid_post();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
